// File: rtl/seq_pkg.sv
// Shared opcode/state encodings and default widths for the sequencer.
package seq_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    OP_ALU  = 2'b00,
    OP_JMP  = 2'b01,
    OP_JZ   = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/seq_ctrl_bit_cnt.sv
// Serial bit counter: synchronous clear, count enable, terminal-count flag.
module bit_cnt #(
  parameter int unsigned N = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [$clog2(N)-1:0] o_cnt,
  output logic                 o_tc
);

  localparam int unsigned CW = $clog2(N);

  logic [CW-1:0] r_cnt;

  assign o_tc  = (r_cnt == CW'(N - 1));
  assign o_cnt = r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer for a bit-serial datapath: fetch, decode, serial exec, PC update.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [ADDR_W-1:0]         i_addr_pc,
  input  logic [1:0]                i_op,
  input  logic [ADDR_W-1:0]         i_target,
  input  logic                      i_zero,
  output logic                      o_con_incr,
  output logic [ADDR_W-1:0]         o_addr_pcin,
  output logic                      o_ir_load,
  output logic                      o_shift_en,
  output logic [$clog2(DATA_W)-1:0] o_bit_idx,
  output logic                      o_busy,
  output logic                      o_halted
);

  localparam int unsigned IW = $clog2(DATA_W);

  state_e            r_state;
  op_e               r_op;
  logic [ADDR_W-1:0] r_target;
  logic [IW-1:0]     w_cnt;
  logic              w_tc;
  logic              w_exec;

  assign w_exec = (r_state == ST_EXEC);

  // Counter is held clear outside EXEC so every ALU instruction starts at bit 0.
  bit_cnt #(.N(DATA_W)) u_bit_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (!w_exec),
    .i_en  (w_exec),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ALU;
      r_target <= '0;
    end else begin
      case (r_state)
        ST_IDLE:   if (i_start) r_state <= ST_FETCH;
        ST_FETCH:  r_state <= ST_DECODE;
        ST_DECODE: begin
          r_op     <= op_e'(i_op);
          r_target <= i_target;
          case (op_e'(i_op))
            OP_ALU:        r_state <= ST_EXEC;
            OP_JMP, OP_JZ: r_state <= ST_UPDATE;
            OP_HALT:       r_state <= ST_HALT;
          endcase
        end
        ST_EXEC:   if (w_tc) r_state <= ST_UPDATE;
        ST_UPDATE: r_state <= ST_FETCH;
        ST_HALT:   r_state <= ST_HALT;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_con_incr  = 1'b0;
    o_addr_pcin = '0;
    o_ir_load   = 1'b0;
    o_shift_en  = 1'b0;
    o_bit_idx   = '0;
    o_busy      = (r_state != ST_IDLE) && (r_state != ST_HALT);
    o_halted    = (r_state == ST_HALT);
    case (r_state)
      ST_FETCH: o_ir_load = 1'b1;
      ST_EXEC: begin
        o_shift_en = 1'b1;
        o_bit_idx  = w_cnt;
      end
      ST_UPDATE: begin
        o_con_incr = 1'b1;
        if (r_op == OP_JMP || (r_op == OP_JZ && i_zero))
          o_addr_pcin = r_target;
        else
          o_addr_pcin = i_addr_pc + ADDR_W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: vector table, scoreboard on PC updates, per-cycle invariants.
module tb_seq_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int IW = $clog2(DW);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] addr_pc;
  logic [1:0]    op;
  logic [AW-1:0] target;
  logic          zero;
  logic          con_incr;
  logic [AW-1:0] addr_pcin;
  logic          ir_load;
  logic          shift_en;
  logic [IW-1:0] bit_idx;
  logic          busy;
  logic          halted;

  always #5 clk = ~clk;

  seq_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_addr_pc   (addr_pc),
    .i_op        (op),
    .i_target    (target),
    .i_zero      (zero),
    .o_con_incr  (con_incr),
    .o_addr_pcin (addr_pcin),
    .o_ir_load   (ir_load),
    .o_shift_en  (shift_en),
    .o_bit_idx   (bit_idx),
    .o_busy      (busy),
    .o_halted    (halted)
  );

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] tgt;
    logic [AW-1:0] pc;
    logic          z;
    logic [AW-1:0] exp_pc;
    int            exp_lat;
    int            exp_shifts;
  } vec_t;

  typedef struct {
    logic [AW-1:0] pc;
    int            lat;
    int            shifts;
  } exp_t;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sbq[$];
  int   lat_cnt = 0;
  int   exp_idx = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {con_incr, addr_pcin, ir_load, shift_en, bit_idx, busy, halted}, 64'd0);
  endtask

  // which: 0 = o_ir_load, 1 = o_con_incr, 2 = EXEC bit 4
  task automatic wait_sig(input int which, input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((which == 0 && ir_load) || (which == 1 && con_incr) ||
          (which == 2 && shift_en && bit_idx == IW'(4)))
        return;
    end
    n_vec++;
    n_bad++;
    $display("FAIL timeout_%s: got no event expected event within %0d cycles", name, limit);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Per-cycle invariants plus scoreboard pop on each PC update.
  always @(negedge clk) begin
    if (ir_load) begin
      lat_cnt = 1;
      exp_idx = 0;
    end else if (lat_cnt > 0) begin
      lat_cnt++;
    end
    check("mutex", 64'(int'(ir_load) + int'(shift_en) + int'(con_incr) <= 1), 64'd1);
    if (!con_incr) check("pcin_zero", 64'(addr_pcin), 64'd0);
    if (!shift_en) check("idx_zero", 64'(bit_idx), 64'd0);
    if (shift_en) begin
      check("bit_idx", 64'(bit_idx), 64'(exp_idx));
      exp_idx++;
    end
    if (con_incr) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_con_incr: got pulse expected none at %0t", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("addr_pcin", 64'(addr_pcin), 64'(e.pc));
        check("latency", 64'(lat_cnt), 64'(e.lat));
        check("shift_count", 64'(exp_idx), 64'(e.shifts));
      end
    end
  end

  initial begin
    vecs.push_back('{op:2'b00, tgt:3'd0, pc:3'd2, z:1'b0, exp_pc:3'd3, exp_lat:DW+3, exp_shifts:DW});
    vecs.push_back('{op:2'b01, tgt:3'd5, pc:3'd3, z:1'b0, exp_pc:3'd5, exp_lat:3, exp_shifts:0});
    vecs.push_back('{op:2'b10, tgt:3'd6, pc:3'd4, z:1'b0, exp_pc:3'd5, exp_lat:3, exp_shifts:0});
    vecs.push_back('{op:2'b10, tgt:3'd6, pc:3'd4, z:1'b1, exp_pc:3'd6, exp_lat:3, exp_shifts:0});
    vecs.push_back('{op:2'b00, tgt:3'd4, pc:3'd7, z:1'b0, exp_pc:3'd0, exp_lat:DW+3, exp_shifts:DW});
    vecs.push_back('{op:2'b01, tgt:3'd0, pc:3'd6, z:1'b0, exp_pc:3'd0, exp_lat:3, exp_shifts:0});
    vecs.push_back('{op:2'b00, tgt:3'd1, pc:3'd5, z:1'b1, exp_pc:3'd6, exp_lat:DW+3, exp_shifts:DW});
    vecs.push_back('{op:2'b10, tgt:3'd1, pc:3'd7, z:1'b1, exp_pc:3'd1, exp_lat:3, exp_shifts:0});
    vecs.push_back('{op:2'b10, tgt:3'd3, pc:3'd7, z:1'b0, exp_pc:3'd0, exp_lat:3, exp_shifts:0});
    vecs.push_back('{op:2'b01, tgt:3'd7, pc:3'd1, z:1'b1, exp_pc:3'd7, exp_lat:3, exp_shifts:0});

    rst = 1'b1; start = 1'b0; addr_pc = '0; op = '0; target = '0; zero = 1'b0;
    @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_no_load", 64'(ir_load), 64'd0);

    // Continuous program run: inputs presented during each FETCH, sampled in DECODE/UPDATE.
    addr_pc = vecs[0].pc; op = vecs[0].op; target = vecs[0].tgt; zero = vecs[0].z;
    pulse_start();
    check("first_ir_load", 64'(ir_load), 64'd1);
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) wait_sig(0, 40, "fetch");
      addr_pc = vecs[i].pc; op = vecs[i].op; target = vecs[i].tgt; zero = vecs[i].z;
      sbq.push_back('{pc:vecs[i].exp_pc, lat:vecs[i].exp_lat, shifts:vecs[i].exp_shifts});
      check("busy_run", 64'(busy), 64'd1);
      wait_sig(1, 40, "update");
    end

    // HALT is terminal: start pulses are ignored.
    wait_sig(0, 40, "fetch_halt");
    op = 2'b11;
    @(negedge clk);
    check("decode_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("halted", 64'(halted), 64'd1);
    check("halt_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 20; i++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_stays", 64'({halted, busy, ir_load}), 64'b100);
    end
    start = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("halt_reset_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_halt_idle", 64'({halted, busy}), 64'd0);

    // Reset mid-EXEC at bit 4 aborts with no PC update.
    addr_pc = 3'd3; op = 2'b00; target = '0; zero = 1'b0;
    pulse_start();
    wait_sig(2, 20, "exec_bit4");
    #2 rst = 1'b1;
    #1 check_all_zero("exec_reset_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_idle", 64'({busy, halted, con_incr}), 64'd0);

    // Restart after abort begins at FETCH.
    addr_pc = 3'd1; op = 2'b01; target = 3'd2; zero = 1'b0;
    pulse_start();
    check("restart_ir_load", 64'(ir_load), 64'd1);
    sbq.push_back('{pc:3'd2, lat:3, shifts:0});
    wait_sig(1, 10, "restart_update");
    @(negedge clk);
    check("refetch_after_update", 64'(ir_load), 64'd1);
    check("sb_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width in bits (serial EXEC cycles per ALU instruction); legal range 2..64.
REQ-002 SHALL have parameter ADDR_W, default 3, program-counter width.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_start  input  1  run request, sampled in IDLE only.
REQ-006 SHALL have port i_addr_pc  input  ADDR_W  current PC value from the PC register.
REQ-007 SHALL have port i_op  input  2  opcode from the instruction register: 00 ALU, 01 JMP, 10 JZ, 11 HALT.
REQ-008 SHALL have port i_target  input  ADDR_W  branch target from the instruction register.
REQ-009 SHALL have port i_zero  input  1  datapath zero flag.
REQ-010 SHALL have port o_con_incr  output  1  PC load enable.
REQ-011 SHALL have port o_addr_pcin  output  ADDR_W  next PC value.
REQ-012 SHALL have port o_ir_load  output  1  instruction-register load strobe.
REQ-013 SHALL have port o_shift_en  output  1  bit-serial datapath shift enable.
REQ-014 SHALL have port o_bit_idx  output  $clog2(DATA_W)  index of the current serial bit, LSB first.
REQ-015 SHALL have port o_busy  output  1  high in every state except IDLE and HALT.
REQ-016 SHALL have port o_halted  output  1  high in HALT.

Function
REQ-017 SHALL implement the FSM states IDLE, FETCH, DECODE, EXEC, UPDATE and HALT.
REQ-018 IDLE SHALL move to FETCH on i_start=1 and otherwise stay in IDLE.
REQ-019 FETCH SHALL assert o_ir_load for exactly one cycle, then move to DECODE.
REQ-020 DECODE SHALL latch i_op and i_target into internal registers; ALU -> EXEC with bit counter=0, JMP/JZ -> UPDATE, HALT -> HALT.
REQ-021 EXEC SHALL assert o_shift_en with o_bit_idx = 0, 1, ... DATA_W-1 on consecutive cycles, moving to UPDATE after the cycle with bit DATA_W-1.
REQ-022 UPDATE SHALL assert o_con_incr for exactly one cycle, then move to FETCH.
REQ-023 o_addr_pcin in UPDATE SHALL be: latched target for JMP; latched target for JZ when i_zero=1 (sampled in UPDATE); otherwise (i_addr_pc+1) mod 2^ADDR_W.
REQ-024 o_addr_pcin SHALL be 0 whenever o_con_incr=0.
REQ-025 PC wrap-around SHALL be plain modulo: with ADDR_W=3, PC 7 advances to 0 with no flag.
REQ-026 Instruction latency SHALL be DATA_W+3 cycles for ALU (FETCH, DECODE, DATA_W x EXEC, UPDATE) and 3 cycles for JMP/JZ.
REQ-027 HALT SHALL be terminal: only i_rst leaves it, and i_start is ignored there.
REQ-028 i_start SHALL be ignored in all states other than IDLE.
REQ-029 o_bit_idx SHALL be 0 outside EXEC.
REQ-030 o_ir_load, o_shift_en and o_con_incr SHALL be mutually exclusive in every cycle.

Reset
REQ-031 Asserting i_rst SHALL immediately, asynchronously, force: state IDLE, bit counter 0, latched op/target 0, every output 0.
REQ-032 Reset asserted mid-EXEC or mid-UPDATE SHALL abort the instruction with no o_con_incr pulse; after release the block waits in IDLE for i_start.

Structure
REQ-033 Package seq_pkg SHALL hold the opcode enum (OP_ALU, OP_JMP, OP_JZ, OP_HALT), the state enum, and the DATA_W/ADDR_W default constants.
REQ-034 The bit counter SHALL be a separate sub-module, bit_cnt (clear, enable, terminal-count output).
REQ-035 All other logic SHALL be a single registered state process plus combinational output decode.

Verification (DATA_W=8, ADDR_W=3)
REQ-036 ALU step: PC=2, op=00, i_start pulse -> o_ir_load in cycle 1, o_shift_en cycles 3-10 with idx 0..7, o_con_incr in cycle 11 with o_addr_pcin=3, FETCH in cycle 12.
REQ-037 Jumps: JMP target=5 -> o_addr_pcin=5 in UPDATE (cycle 3); JZ target=6 with i_zero=0, PC=4 -> 5; with i_zero=1 -> 6.
REQ-038 Wrap: PC=7, ALU -> o_addr_pcin=0.
REQ-039 HALT: op=11 -> o_halted=1, o_busy=0 from cycle 3; i_start pulses ignored for 20 cycles; i_rst -> IDLE.
REQ-040 Reset at EXEC bit 4 -> all outputs 0 immediately, no o_con_incr; a later i_start restarts at FETCH.
REQ-041 Every cycle SHALL be checked for REQ-030 mutual exclusion and for o_addr_pcin=0 whenever o_con_incr=0.
